// File: rtl/mul_pkg.sv
// Shared accelerator package: FSM state types for the multiplier and divider.
package mul_pkg;

    typedef enum logic {
        IDLE,
        COMP
    } mul_state_t;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_SHIFT,
        DIV_DONE
    } div_state_t;

endpackage : mul_pkg

// File: rtl/mul_lopd.sv
// Leading-one position detector: index of the highest set bit of vec (0 when vec is zero).
module lopd #(
    parameter int D_W = 32
) (
    input  logic [D_W-1:0]         vec,
    output logic [$clog2(D_W)-1:0] msb
);

    localparam int LW = $clog2(D_W);

    always_comb begin
        msb = '0;
        // Scan upward so the highest set bit is the last one written.
        for (int i = 0; i < D_W; i++) begin
            if (vec[i]) begin
                msb = i[LW-1:0];
            end
        end
    end

endmodule : lopd

// File: rtl/mul.sv
// Sequential unsigned multiplier: adds A shifted by each set bit of B, one set bit per cycle.
module mul
    import mul_pkg::*;
#(
    parameter int D_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [D_W-1:0]     multiplicand,
    input  logic [D_W-1:0]     multiplier,
    output logic [2*D_W-1:0]   product,
    output logic               out_valid
);

    localparam int LW = $clog2(D_W);
    localparam logic [D_W-1:0] ONE = {{(D_W-1){1'b0}}, 1'b1};

    mul_state_t         state_q,     state_d;
    logic [2*D_W-1:0]   mcand_q,     mcand_d;
    logic [D_W-1:0]     mplier_q,    mplier_d;
    logic [2*D_W-1:0]   acc_q,       acc_d;
    logic [2*D_W-1:0]   product_q,   product_d;
    logic               out_valid_q, out_valid_d;
    logic [LW-1:0]      msb;

    lopd #(.D_W(D_W)) u_lopd (
        .vec (mplier_q),
        .msb (msb)
    );

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        product_d   = product_q;
        out_valid_d = out_valid_q;
        if (enable) begin
            case (state_q)
                IDLE: begin
                    out_valid_d = 1'b0;
                    if (in_valid) begin
                        mcand_d  = {{D_W{1'b0}}, multiplicand};
                        mplier_d = multiplier;
                        acc_d    = '0;
                        state_d  = COMP;
                    end
                end
                COMP: begin
                    if (mplier_q != '0) begin
                        acc_d    = acc_q + (mcand_q << msb);
                        mplier_d = mplier_q & ~(ONE << msb);
                    end else begin
                        product_d   = acc_q;
                        out_valid_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign product   = product_q;
    assign out_valid = out_valid_q;

endmodule : mul

// File: tb/tb_mul.sv
// Self-checking bench for mul: directed corner cases plus randomized operands against a plain arithmetic model.
module tb_mul;

    localparam int D_W = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic               in_valid;
    logic               in_ready;
    logic [D_W-1:0]     multiplicand;
    logic [D_W-1:0]     multiplier;
    logic [2*D_W-1:0]   product;
    logic               out_valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mul #(.D_W(D_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .out_valid    (out_valid)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid, counting enabled edges; optional random stalls.
    task automatic wait_done(input string tag, input bit stall, output int lat);
        int guard;
        lat   = 0;
        guard = 0;
        while (!out_valid && guard < 400) begin
            check({tag, "_in_ready_comp"}, 64'(in_ready), 64'd0);
            enable = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
            guard++;
            if (enable) lat++;
        end
        enable = 1'b1;
        check({tag, "_done"}, 64'(out_valid), 64'd1);
    endtask

    // One full transaction: accept, wait, check result/latency, then check the clearing edge.
    task automatic run_op(input string tag, input logic [D_W-1:0] a, input logic [D_W-1:0] b,
                          input bit stall);
        logic [63:0] exp_p;
        int          exp_lat;
        int          lat;
        exp_p   = 64'(a) * 64'(b);
        exp_lat = $countones(b) + 1;
        multiplicand = a;
        multiplier   = b;
        in_valid     = 1'b1;
        enable       = 1'b1;
        check({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        wait_done(tag, stall, lat);
        check({tag, "_product"}, product, exp_p);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        tick();
        check({tag, "_ov_clear"}, 64'(out_valid), 64'd0);
        check({tag, "_product_hold"}, product, exp_p);
        $display("op %s a=%h b=%h product=%h latency=%0d", tag, a, b, product, lat);
    endtask

    initial begin
        int          lat;
        logic [D_W-1:0] ra;
        logic [D_W-1:0] rb;
        logic [63:0]    held;

        rst          = 1'b0;
        enable       = 1'b1;
        in_valid     = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        tick();
        tick();
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_product",   product,        64'd0);
        rst = 1'b1;
        tick();

        // 7*6: result on the 3rd edge after accept
        run_op("a7b6", 32'd7, 32'd6, 1'b0);
        run_op("max",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("b0",   32'd123, 32'd0, 1'b0);
        run_op("a0",   32'd0, 32'h8000_0000, 1'b0);
        run_op("b1",   32'hDEAD_BEEF, 32'd1, 1'b0);

        // Stall for 4 cycles after the first COMP step
        multiplicand = 32'd5;
        multiplier   = 32'd3;
        in_valid     = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        held   = product;
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_ov",      64'(out_valid), 64'd0);
            check("stall_product", product,        held);
            check("stall_ready",   64'(in_ready),  64'd0);
        end
        enable = 1'b1;
        wait_done("stall", 1'b0, lat);
        check("stall_product_final", product, 64'd15);
        check("stall_latency", 64'(lat + 1), 64'd3);
        $display("op stall a=5 b=3 product=%h latency=%0d", product, lat + 1);
        tick();

        // Reset mid-computation aborts without a result
        multiplicand = 32'd9;
        multiplier   = 32'hFF;
        in_valid     = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        #1;
        check("midrst_ov",      64'(out_valid), 64'd0);
        check("midrst_product", product,        64'd0);
        check("midrst_ready",   64'(in_ready),  64'd1);
        tick();
        check("midrst_hold_ov", 64'(out_valid), 64'd0);
        rst = 1'b1;
        tick();
        run_op("after_rst", 32'd2, 32'd3, 1'b0);

        // in_valid held high across COMP; second pair accepted on the clearing edge
        multiplicand = 32'd11;
        multiplier   = 32'd13;
        in_valid     = 1'b1;
        tick();
        multiplicand = 32'd1;
        multiplier   = 32'd1;
        wait_done("hold1", 1'b0, lat);
        check("hold1_product", product, 64'd143);
        check("hold1_latency", 64'(lat), 64'd4);
        $display("op hold1 a=11 b=13 product=%h latency=%0d", product, lat);
        tick();
        in_valid = 1'b0;
        check("hold2_ov_clear", 64'(out_valid), 64'd0);
        check("hold2_accepted", 64'(in_ready),  64'd0);
        wait_done("hold2", 1'b0, lat);
        check("hold2_product", product, 64'd1);
        check("hold2_latency", 64'(lat), 64'd2);
        $display("op hold2 a=1 b=1 product=%h latency=%0d", product, lat);
        tick();

        // Randomized operands, mixed-density multipliers, random stalls
        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            case (n % 4)
                0:       rb = $urandom;
                1:       rb = $urandom & $urandom & $urandom;
                2:       rb = $urandom | $urandom;
                default: rb = 32'(1) << $urandom_range(0, D_W - 1);
            endcase
            run_op($sformatf("rnd%0d", n), ra, rb, n[0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mul

// File: doc/mul.md
MUL -- requirements
Module: mul

Interface
REQ-001 SHALL have parameter D_W, default 32, giving the operand width in bits; legal values are powers of two from 8 to 32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port enable, input, 1 bit: global stall; when 0, all registers hold their values.
REQ-005 SHALL have port in_valid, input, 1 bit: operands are valid this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit: the block is in IDLE and will accept operands.
REQ-007 SHALL have port multiplicand, input, D_W bits: unsigned operand A.
REQ-008 SHALL have port multiplier, input, D_W bits: unsigned operand B, scanned bit by bit.
REQ-009 SHALL have port product, output, 2*D_W bits: unsigned A*B, registered.
REQ-010 SHALL have port out_valid, output, 1 bit: product is valid.

Function
REQ-011 SHALL implement a two-state FSM with states IDLE and COMP; the FSM advances only on edges where enable=1.
REQ-012 in_ready SHALL be combinationally 1 exactly when state=IDLE, independent of enable.
REQ-013 Accept: IDLE, enable=1 and in_valid=1 SHALL do all of the following on the same edge:
- latch A into the multiplicand register, zero-extended to 2*D_W bits;
- latch B into the remaining-multiplier register;
- clear the accumulator;
- go to COMP.
REQ-014 On every enabled IDLE edge, out_valid SHALL be cleared, whether or not an accept happens.
REQ-015 A lopd sub-instance SHALL return msb, the index of the leading one of the remaining-multiplier register.
REQ-016 COMP step: when the remaining multiplier is nonzero, each enabled edge SHALL add (A << msb) to the accumulator and clear bit msb of the remaining multiplier.
REQ-017 COMP finish: when the remaining multiplier is zero, the enabled edge SHALL load product from the accumulator, set out_valid=1 and go to IDLE.
REQ-018 Latency SHALL be popcount(B)+1 enabled cycles, counted from the accept edge to the edge that sets out_valid: minimum 1 (B=0), maximum D_W+1.
REQ-019 product and out_valid SHALL hold until the next enabled IDLE edge; product keeps its last value after out_valid drops.
REQ-020 in_valid while in COMP SHALL be ignored: operands are neither captured nor queued.
REQ-021 Back-to-back operation: an accept on the edge that clears out_valid SHALL be legal, giving throughput of one result per latency+1 cycles.
REQ-022 The accumulator SHALL be 2*D_W bits wide and SHALL never overflow; no truncation is permitted.
REQ-023 When enable=0 during COMP, the partial accumulator and remaining multiplier SHALL be preserved exactly.

Reset
REQ-024 rst=0 SHALL asynchronously force state=IDLE, product=0, out_valid=0, accumulator=0 and remaining multiplier=0.
REQ-025 Reset asserted mid-COMP SHALL abort the operation with no out_valid pulse; the first accept after rst is released SHALL behave as from power-up.
REQ-026 in_ready SHALL read 1 while rst=0.

Structure
REQ-027 The state enum type (IDLE, COMP) SHALL live in the shared accelerator package alongside the divider's state type; no other package contents are required.
REQ-028 The existing lopd leading-one detector SHALL be the only sub-module: one instance on the remaining multiplier, output width $clog2(D_W).
REQ-029 The datapath SHALL use one 2*D_W-bit adder and one variable barrel shift; no hard multiplier primitive is permitted.

Verification
REQ-030 A=7, B=6, enable=1: product=42 and out_valid=1 on the 3rd edge after accept, then out_valid=0 on the next edge.
REQ-031 A=0xFFFFFFFF, B=0xFFFFFFFF: product=0xFFFFFFFE00000001 after 33 enabled cycles; in_ready=0 throughout COMP.
REQ-032 A=123, B=0: product=0 after 1 cycle; A=0, B=0x80000000: product=0 after 2 cycles.
REQ-033 A=5, B=3 with enable=0 for 4 cycles mid-COMP: product=15 after 3 enabled cycles; outputs frozen during the stall.
REQ-034 A=9, B=0xFF, rst pulsed low after 4 cycles: out_valid and product read 0 immediately; a new A=2, B=3 then yields 6 after 3 cycles.
REQ-035 in_valid held high with A=11, B=13 then changed to A=1, B=1 during COMP: product=143; the second pair is accepted only on the out_valid-clearing edge and yields 1.
